pivot_search_axis: RTL
======================

Name: pivot_search_axis

Overview:
- Streaming arg-extremum finder for the solver pivot step.
- Consumes one N_ROWS x N_COLS matrix per frame over a ready/valid stream and returns the row/column index and value of the selected pivot element.
- Selection is max signed, min signed or max magnitude, with optional diagonal exclusion.
- Adds backpressure on both sides, frame-length checking and an explicit "no candidate" result.

Parameters:
- WIDTH, 16, element width in bits, two's complement.
- N_ROWS, 4, matrix rows (>=1).
- N_COLS, 4, matrix columns (>=1).
- EXCL_DIAG, 1, 1 = elements with row==col are never candidates.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- mode  in  2  selection mode, sampled on the first accepted beat of a frame: 0 max signed, 1 min signed, 2 max |x|, 3 reserved (treated as 0).
- s_valid  in  1  input element valid.
- s_ready  out  1  block accepts element.
- s_data  in  WIDTH  element, signed.
- s_last  in  1  last element of frame.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts result.
- m_row  out  clog2(N_ROWS) (min 1)  pivot row index.
- m_col  out  clog2(N_COLS) (min 1)  pivot column index.
- m_value  out  WIDTH  pivot element as received (not abs).
- m_found  out  1  1 = at least one candidate seen.
- m_err  out  2  bit0 short frame, bit1 long frame.

Behaviour:
- Transfer occurs when valid && ready on the same edge.
- Element ordering is column-major: beat k maps to row = k mod N_ROWS, col = k / N_ROWS. Row and col counters wrap row first, then col.
- States:
  - SCAN: s_ready=1, m_valid=0.
  - DRAIN: s_ready=1, beats discarded.
  - HOLD: s_ready=0, m_valid=1.
- Reset (rst=0 at edge): state SCAN, counters 0, best cleared, m_valid=0, m_row=m_col=0, m_value=0, m_found=0, m_err=0. Reset wins over any handshake in the same cycle. Reset mid-frame or in HOLD discards all partial and unaccepted results.
- SCAN, per accepted beat:
  - The beat is a candidate unless EXCL_DIAG && row==col.
  - A candidate replaces best if no best exists yet, or if its key is strictly better: mode 0 greater, mode 1 less, mode 2 larger magnitude.
  - Ties keep the earliest element.
- Magnitude is computed at WIDTH+1 bits, so |-2^(WIDTH-1)| = 2^(WIDTH-1) with no saturation.
- The mode latched on beat 0 holds for the whole frame. Changes to mode mid-frame are ignored.
- Frame end, evaluated on each accepted beat:
  - s_last=1 before beat N_ROWS*N_COLS-1: set err bit0, go to HOLD.
  - Beat N_ROWS*N_COLS-1 with s_last=1: err=0, go to HOLD.
  - Beat N_ROWS*N_COLS-1 with s_last=0: set err bit1, go to DRAIN.
- DRAIN: accept and discard beats until a beat with s_last=1, then go to HOLD. Best is not updated in DRAIN.
- The last beat is a full candidate; its contribution appears in the result.
- Latency: m_valid rises the cycle after the final accepted beat (after the s_last beat when exiting DRAIN).
- m_row, m_col, m_value, m_found and m_err are registered and stable while m_valid=1.
- HOLD: m_valid stays high until m_ready=1. On that edge, go to SCAN, clear counters, best and err, and drop m_valid. s_ready rises on the following cycle, so there is no same-cycle input/output overlap.
- m_found=0 when no candidate was seen (e.g. 1x1 with EXCL_DIAG, or a short frame of diagonal-only beats). In that case m_row=m_col=0 and m_value=0.
- Backpressure: gaps in s_valid are allowed anywhere. A frame has no timeout.

Test Plan:
- 4x4 mode 0, EXCL_DIAG=1, values 0..15 column-major with the diagonal set to 100 -> m_row=2, m_col=3, m_value=14, found=1, err=0, m_valid one cycle after beat 15.
- Mode 1 with -5 at (1,0) and (3,2), all others 0 -> first occurrence wins: m_row=1, m_col=0, m_value=-5 (0xFFFB).
- Mode 2 with 0x8000 at (0,1) and 0x7FFF at (2,0) -> m_row=0, m_col=1, m_value=0x8000.
- s_last on beat 5, then a frame of 18 beats with s_last on beat 17 -> first result err=01; second result err=10, with beats 16..17 ignored and the result taken from the first 16.
- Hold m_ready=0 for 10 cycles -> m_valid and outputs stable, s_ready=0. Then m_ready=1 -> m_valid drops and s_ready=1 next cycle.
- Assert rst=0 on beat 7 of a frame, then send a full clean frame -> result reflects the new frame only, err=0. Also 1x1 with EXCL_DIAG=1 -> found=0.

Source files
------------

// File: rtl/pivot_search_axis.sv
// pivot_search_axis: streaming arg-extremum finder for the solver pivot step.
// Consumes one N_ROWS x N_COLS matrix per frame (column-major beats) and
// reports the row/col/value of the selected pivot, a found flag and
// frame-length error bits.
//
// Handshake: a beat or result moves on a rising edge where valid && ready are
// both high; valid never waits on ready, s_ready is high in SCAN and DRAIN,
// m_valid is high only in HOLD, so input and result never overlap in a cycle.
module pivot_search_axis #(
    parameter int WIDTH     = 16,
    parameter int N_ROWS    = 4,
    parameter int N_COLS    = 4,
    parameter int EXCL_DIAG = 1,
    localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1,
    localparam int CW = (N_COLS > 1) ? $clog2(N_COLS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [RW-1:0]    m_row,
    output logic [CW-1:0]    m_col,
    output logic [WIDTH-1:0] m_value,
    output logic             m_found,
    output logic [1:0]       m_err
);

    typedef enum logic [1:0] {
        SCAN  = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [RW-1:0]    r_row;
    logic [CW-1:0]    r_col;
    logic [1:0]       r_mode;
    logic             r_found;
    logic [RW-1:0]    r_best_row;
    logic [CW-1:0]    r_best_col;
    logic [WIDTH-1:0] r_best_val;
    logic [1:0]       r_err;

    logic             w_first;
    logic             w_final;
    logic             w_diag;
    logic             w_cand;
    logic [1:0]       w_mode_in;
    logic [1:0]       w_mode_eff;
    logic [WIDTH:0]   w_ext_in;
    logic [WIDTH:0]   w_ext_best;
    logic [WIDTH:0]   w_mag_in;
    logic [WIDTH:0]   w_mag_best;
    logic             w_better;
    logic             w_take;

    // Beat position, candidate qualification and "strictly better" compare.
    always_comb begin
        w_first    = (r_row == '0) && (r_col == '0);
        w_final    = (r_row == RW'(N_ROWS - 1)) && (r_col == CW'(N_COLS - 1));
        w_diag     = (EXCL_DIAG != 0) && (int'(r_row) == int'(r_col));
        w_cand     = !w_diag;
        // Reserved mode 3 behaves as max signed.
        w_mode_in  = (mode == 2'd3) ? 2'd0 : mode;
        w_mode_eff = w_first ? w_mode_in : r_mode;
        // Magnitudes at WIDTH+1 bits so the most negative value does not wrap.
        w_ext_in   = {s_data[WIDTH-1], s_data};
        w_ext_best = {r_best_val[WIDTH-1], r_best_val};
        w_mag_in   = w_ext_in[WIDTH] ? (~w_ext_in + {{WIDTH{1'b0}}, 1'b1}) : w_ext_in;
        w_mag_best = w_ext_best[WIDTH] ? (~w_ext_best + {{WIDTH{1'b0}}, 1'b1}) : w_ext_best;
        case (w_mode_eff)
            2'd1:    w_better = $signed(s_data) < $signed(r_best_val);
            2'd2:    w_better = w_mag_in > w_mag_best;
            default: w_better = $signed(s_data) > $signed(r_best_val);
        endcase
        // Strict compare: ties keep the earliest element.
        w_take = w_cand && (!r_found || w_better);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= SCAN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        s_ready      = 1'b0;
        m_valid      = 1'b0;
        case (r_state)
            SCAN: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    if (s_last) begin
                        w_state_next = HOLD;
                    end else if (w_final) begin
                        w_state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                s_ready = 1'b1;
                if (s_valid && s_last) begin
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    w_state_next = SCAN;
                end
            end
            default: begin
                w_state_next = SCAN;
            end
        endcase
    end

    // Beat counters, latched mode, running best and error bits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_row      <= '0;
            r_col      <= '0;
            r_mode     <= 2'd0;
            r_found    <= 1'b0;
            r_best_row <= '0;
            r_best_col <= '0;
            r_best_val <= '0;
            r_err      <= 2'b00;
        end else begin
            case (r_state)
                SCAN: begin
                    if (s_valid) begin
                        if (w_first) begin
                            r_mode <= w_mode_in;
                        end
                        if (w_take) begin
                            r_found    <= 1'b1;
                            r_best_row <= r_row;
                            r_best_col <= r_col;
                            r_best_val <= s_data;
                        end
                        if (r_row == RW'(N_ROWS - 1)) begin
                            r_row <= '0;
                            r_col <= r_col + CW'(1);
                        end else begin
                            r_row <= r_row + RW'(1);
                        end
                        if (s_last) begin
                            r_err <= w_final ? 2'b00 : 2'b01;
                        end else if (w_final) begin
                            r_err <= 2'b10;
                        end
                    end
                end
                HOLD: begin
                    if (m_ready) begin
                        r_row      <= '0;
                        r_col      <= '0;
                        r_found    <= 1'b0;
                        r_best_row <= '0;
                        r_best_col <= '0;
                        r_best_val <= '0;
                        r_err      <= 2'b00;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign m_row   = r_best_row;
    assign m_col   = r_best_col;
    assign m_value = r_best_val;
    assign m_found = r_found;
    assign m_err   = r_err;

endmodule
